// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: register index and hazard-control FSM state.
package cpu_types_pkg;
    localparam int REG_W = 5;
    typedef logic [REG_W-1:0] regbits_t;
    typedef enum logic [1:0] {RUN, REDIR_PEND, HALTED} hazard_state_t;
endpackage

// File: rtl/hazard_unit_if.sv
// Hazard-control bundle between the hazard block (hz) and the datapath (dp).
interface hazard_unit_if;
    import cpu_types_pkg::*;
    regbits_t id_rs;
    regbits_t id_rt;
    logic     id_uses_rt;
    regbits_t ex_rd;
    logic     ex_memread;
    logic     mem_dREN;
    logic     mem_dWEN;
    logic     ihit;
    logic     dhit;
    logic     ex_redirect;
    logic     wb_halt;
    logic     pc_en;
    logic     ifid_en;
    logic     idex_en;
    logic     exmem_en;
    logic     memwb_en;
    logic     ifid_flush;
    logic     idex_flush;
    logic     halted;

    modport hz (
        input  id_rs, id_rt, id_uses_rt, ex_rd, ex_memread, mem_dREN, mem_dWEN,
               ihit, dhit, ex_redirect, wb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted
    );
    modport dp (
        output id_rs, id_rt, id_uses_rt, ex_rd, ex_memread, mem_dREN, mem_dWEN,
               ihit, dhit, ex_redirect, wb_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// Latency: count visible one cycle after inc; no backpressure (holds at all-ones).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (inc && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush control for hazards forwarding cannot resolve; HAZARD_STATS_EN adds counters.
// Latency: controls are combinational from state and inputs; redirects and halt are remembered in a 3-state FSM.
// Backpressure: memory wait freezes every latch; a redirect arriving during the freeze is held until it clears.
module hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  regbits_t         id_rs,
    input  regbits_t         id_rt,
    input  logic             id_uses_rt,
    input  regbits_t         ex_rd,
    input  logic             ex_memread,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             ex_redirect,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    hazard_unit_if hz_if ();

    assign hz_if.id_rs       = id_rs;
    assign hz_if.id_rt       = id_rt;
    assign hz_if.id_uses_rt  = id_uses_rt;
    assign hz_if.ex_rd       = ex_rd;
    assign hz_if.ex_memread  = ex_memread;
    assign hz_if.mem_dREN    = mem_dREN;
    assign hz_if.mem_dWEN    = mem_dWEN;
    assign hz_if.ihit        = ihit;
    assign hz_if.dhit        = dhit;
    assign hz_if.ex_redirect = ex_redirect;
    assign hz_if.wb_halt     = wb_halt;

    hazard_state_t state_q, state_d;
    logic          redirect_pend_q, redirect_pend_d;
    logic          dwait, loaduse, redirect;
    logic          pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
    logic          ifid_flush_c, idex_flush_c, halted_c;

    always_comb begin
        dwait   = (hz_if.mem_dREN | hz_if.mem_dWEN) & ~hz_if.dhit;
        loaduse = hz_if.ex_memread & (hz_if.ex_rd != '0) &
                  ((hz_if.ex_rd == hz_if.id_rs) |
                   (hz_if.id_uses_rt & (hz_if.ex_rd == hz_if.id_rt)));
        redirect = hz_if.ex_redirect | redirect_pend_q;

        pc_en_c      = 1'b1;
        ifid_en_c    = 1'b1;
        idex_en_c    = 1'b1;
        exmem_en_c   = 1'b1;
        memwb_en_c   = 1'b1;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        halted_c     = 1'b0;
        state_d      = state_q;

        if (state_q == HALTED) begin
            {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '0;
            halted_c = 1'b1;
        end else if (dwait) begin
            {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '0;
            if (redirect) state_d = REDIR_PEND;
        end else if (redirect) begin
            // The ID instruction is discarded, so a pending load-use needs no bubble.
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
            state_d      = RUN;
        end else if (loaduse) begin
            pc_en_c      = 1'b0;
            ifid_en_c    = 1'b0;
            idex_flush_c = 1'b1;
        end else if (!hz_if.ihit) begin
            pc_en_c      = 1'b0;
            ifid_flush_c = 1'b1;
        end

        // Halt retires only when WB actually advances this cycle.
        if ((state_q != HALTED) && hz_if.wb_halt && memwb_en_c)
            state_d = HALTED;
        redirect_pend_d = (state_d == REDIR_PEND);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q         <= RUN;
            redirect_pend_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            redirect_pend_q <= redirect_pend_d;
        end
    end

    // Controls are forced inactive while reset is asserted, independent of the clock.
    assign hz_if.pc_en      = pc_en_c      & nRST;
    assign hz_if.ifid_en    = ifid_en_c    & nRST;
    assign hz_if.idex_en    = idex_en_c    & nRST;
    assign hz_if.exmem_en   = exmem_en_c   & nRST;
    assign hz_if.memwb_en   = memwb_en_c   & nRST;
    assign hz_if.ifid_flush = ifid_flush_c & nRST;
    assign hz_if.idex_flush = idex_flush_c & nRST;
    assign hz_if.halted     = halted_c     & nRST;

    assign pc_en      = hz_if.pc_en;
    assign ifid_en    = hz_if.ifid_en;
    assign idex_en    = hz_if.idex_en;
    assign exmem_en   = hz_if.exmem_en;
    assign memwb_en   = hz_if.memwb_en;
    assign ifid_flush = hz_if.ifid_flush;
    assign idex_flush = hz_if.idex_flush;
    assign halted     = hz_if.halted;

`ifdef HAZARD_STATS_EN
    logic stall_inc, flush_inc;
    assign stall_inc = ~pc_en_c & (state_q != HALTED);
    assign flush_inc = ifid_flush_c | idex_flush_c;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .clear (1'b0),
        .inc   (stall_inc),
        .cnt   (stall_cnt)
    );
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .clear (1'b0),
        .inc   (flush_inc),
        .cnt   (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: expected control words queued per step, compared mid-cycle.
module tb_hazard_unit;
    import cpu_types_pkg::*;

    localparam int CNT_W = 32;
    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted}
    localparam logic [7:0] ALL    = 8'b11111_00_0;
    localparam logic [7:0] FRZ    = 8'b00000_00_0;
    localparam logic [7:0] LU     = 8'b00111_01_0;
    localparam logic [7:0] REDIR  = 8'b11111_11_0;
    localparam logic [7:0] IMISS  = 8'b01111_10_0;
    localparam logic [7:0] HALT   = 8'b00000_00_1;
    localparam logic [7:0] RSTVAL = 8'b00000_00_0;

    logic             CLK = 1'b0;
    logic             nRST;
    regbits_t         id_rs, id_rt, ex_rd;
    logic             id_uses_rt, ex_memread, mem_dREN, mem_dWEN;
    logic             ihit, dhit, ex_redirect, wb_halt;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [7:0]       ctl;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] ctl;
    } exp_t;
    exp_t sb[$];

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_memread(ex_memread),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .ihit(ihit), .dhit(dhit), .ex_redirect(ex_redirect), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted};

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic [4:0] rd, input logic mr, input logic dr, input logic dw,
                         input logic ih, input logic dh, input logic rdr, input logic hlt);
        id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_rd = rd; ex_memread = mr;
        mem_dREN = dr; mem_dWEN = dw; ihit = ih; dhit = dh; ex_redirect = rdr; wb_halt = hlt;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic chk_ctl(input string tag, input logic [7:0] exp);
        checks++;
        assert (ctl === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, ctl, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One pipeline cycle: queue the expectation, compare mid-cycle, land just after the next edge.
    task automatic cyc(input string tag, input logic [7:0] exp);
        exp_t e;
        e.tag = tag;
        e.ctl = exp;
        sb.push_back(e);
        @(negedge CLK);
        e = sb.pop_front();
        chk_ctl(e.tag, e.ctl);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        idle();
        #2;
        chk_ctl("reset_ctl", RSTVAL);
        chk_cnt("reset_stall", stall_cnt, '0);
        chk_cnt("reset_flush", flush_cnt, '0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Two load-use bubbles and one redirect from a clean reset.
        drive(5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("loaduse_rs", LU);
        idle();
        cyc("after_bubble", ALL);
        drive(5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("loaduse_rt", LU);
        idle();
        cyc("after_bubble2", ALL);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("redirect", REDIR);
        idle();
        cyc("after_redirect", ALL);
`ifdef HAZARD_STATS_EN
        chk_cnt("stall_cnt", stall_cnt, 32'd2);
        chk_cnt("flush_cnt", flush_cnt, 32'd3);
`else
        chk_cnt("stall_cnt_off", stall_cnt, 32'd0);
        chk_cnt("flush_cnt_off", flush_cnt, 32'd0);
`endif

        drive(5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("rt_not_used", ALL);
        drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("load_r0", ALL);
        drive(5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("redir_over_lu", REDIR);

        // Redirect held across a 3-cycle data wait, then applied with EX no longer asserting it.
        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            cyc("dwait_redir", FRZ);
        end
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("pend_redirect", REDIR);
        idle();
        cyc("run_after_pend", ALL);

        drive(5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("dwait_over_lu", FRZ);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("dwait_no_pend", ALL);

        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("imiss_redirect", REDIR);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("imiss_only", IMISS);
        drive(5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("lu_over_imiss", LU);

        // Halt cannot retire while WB is frozen by a data wait.
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("halt_in_dwait", FRZ);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("halt_retire", ALL);
        for (int i = 0; i < 12; i++) begin
            drive(5'd3, 5'd0, 1'b0, 5'd3, i[0], 1'b0, 1'b0, i[1], 1'b1, i[2], 1'b0);
            cyc("halted", HALT);
        end

        // Asynchronous reset mid-halt, released before any clock edge.
        nRST = 1'b0;
        #1;
        chk_ctl("async_rst_ctl", RSTVAL);
        chk_cnt("async_rst_stall", stall_cnt, '0);
        chk_cnt("async_rst_flush", flush_cnt, '0);
        #1;
        nRST = 1'b1;
        idle();
        cyc("run_after_rst", ALL);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("imiss_after_rst", IMISS);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control counterpart to the forwarding unit.
- The forwarding unit resolves hazards by steering operands. This block resolves the hazards forwarding cannot: load-use, taken branch/jump redirects, instruction/data memory wait, and halt.
- It drives the enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- It contains a small FSM that remembers redirects and halts across memory stalls.

Parameters:
- CNT_W, 32, width of the stall and flush statistics counters (used only with the optional feature).

Ports:
- CLK  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- id_rs  in  5  rs of the instruction in ID (regbits_t).
- id_rt  in  5  rt of the instruction in ID (regbits_t).
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_rd  in  5  destination of the instruction in EX (regbits_t).
- ex_memread  in  1  EX instruction is a load.
- mem_dREN  in  1  MEM stage data read.
- mem_dWEN  in  1  MEM stage data write.
- ihit  in  1  instruction memory ready.
- dhit  in  1  data memory ready.
- ex_redirect  in  1  EX resolved a taken branch or a jump.
- wb_halt  in  1  halt instruction in WB.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID latch enable.
- idex_en  out  1  ID/EX latch enable.
- exmem_en  out  1  EX/MEM latch enable.
- memwb_en  out  1  MEM/WB latch enable.
- ifid_flush  out  1  IF/ID flush (load NOP).
- idex_flush  out  1  ID/EX flush (load NOP).
- halted  out  1  processor halted.
- stall_cnt  out  CNT_W  stall cycles counted.
- flush_cnt  out  CNT_W  flushes counted.

Behaviour:
- Reset: CLK is the only clock; nRST is asynchronous and active-low. While nRST=0, the state is RUN, redirect_pend=0, counters=0, all *_en=0, both flushes=0, halted=0.
- FSM states: RUN, REDIR_PEND, HALTED (hazard_state_t). Outputs are combinational from state and inputs; state and redirect_pend are registered.
- Definition: dwait = (mem_dREN | mem_dWEN) & !dhit.
- Definition: loaduse = ex_memread & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
- Priority, highest first: HALTED > dwait > redirect > loaduse > !ihit > normal.
- HALTED:
  - All *_en=0, flushes=0, halted=1.
  - Exits only on reset.
  - Entered from any state on wb_halt=1 when memwb_en would be 1 in that cycle.
- dwait:
  - All *_en=0 and flushes=0 (full freeze).
  - If ex_redirect=1 in a dwait cycle: next state is REDIR_PEND. The redirect must not be lost while EX is frozen.
- redirect (ex_redirect=1 in RUN without dwait, or state REDIR_PEND without dwait):
  - pc_en=1, ifid_flush=1, idex_flush=1, the other enables=1.
  - Next state is RUN.
  - The redirect overrides loaduse: the ID instruction is discarded, so no bubble is needed.
  - If !ihit in the same cycle, the redirect is still applied. The PC takes the target, and IF/ID is flushed regardless of ihit.
- loaduse (RUN, no dwait, no redirect):
  - pc_en=0, ifid_en=0, idex_flush=1; exmem_en=1, memwb_en=1.
  - Exactly one bubble, because the bubble clears ex_memread in the next cycle.
- !ihit only:
  - pc_en=0, ifid_flush=1; downstream enables=1 (drain continues).
- normal: all *_en=1, flushes=0.
- Enable/flush exclusivity: no cycle asserts both ifid_en=0 and ifid_flush=1. A flushed latch is also enabled.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - stall_cnt increments on every cycle with pc_en=0 and state!=HALTED.
  - flush_cnt increments on every cycle with ifid_flush|idex_flush.
  - Both saturate at all-ones and are cleared by reset.
- Undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops are built.

Decomposition:
- cpu_types_pkg: regbits_t (existing) and hazard_state_t enum {RUN, REDIR_PEND, HALTED}.
- hazard_unit_if interface with modports hz (block) and dp (datapath), mirroring the forwarding interface style.
- Sub-module sat_counter (width CNT_W, inc, clear), instantiated twice under HAZARD_STATS_EN.

Test Plan:
- Load-use: lw $3 in EX (ex_memread=1, ex_rd=3), ID add reads rs=3 → one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables=1.
- Redirect during dwait: ex_redirect=1, mem_dREN=1, dhit=0 for 3 cycles → all enables 0 for 3 cycles, state REDIR_PEND. On the dhit=1 cycle: pc_en=1, ifid_flush=1, idex_flush=1, then RUN.
- rd=$0 load: ex_memread=1, ex_rd=0, id_rs=0 → no stall, all enables=1.
- !ihit with redirect: ihit=0, ex_redirect=1 → pc_en=1 and both flushes asserted. Then with ihit=0 only → pc_en=0, ifid_flush=1, memwb_en=1.
- Halt: wb_halt=1 → halted=1 next cycle and all enables 0 for 10+ cycles. Pulsing nRST low mid-halt → outputs go to reset values immediately (asynchronously), and the block returns to RUN after release.
- HAZARD_STATS_EN: 2 load-use bubbles plus 1 redirect → stall_cnt=2, flush_cnt=3.
